clk_period_monitor: RTL and testbench

//  Receive end of the divided-clock timebase: takes one slow square wave (e.g. the half-second

---
 rtl/clk_mon_pkg.sv | 24 ++
 rtl/sync_edge_det.sv | 44 ++++
 rtl/clk_period_monitor.sv | 137 +++++++++++++
 tb/tb_clk_period_monitor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared constants, state encoding and the tolerance-window helper for the
// clock period monitor.
package clk_mon_pkg;

  localparam int DEF_CNT_W       = 27;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_EXPECT_HALF = 25_000_001;
  localparam int DEF_TOL         = 1_000;
  localparam int DEF_TIMEOUT     = 50_000_000;

  typedef logic [1:0] state_t;

  localparam state_t ST_ACQUIRE = 2'd0;
  localparam state_t ST_HIGH    = 2'd1;
  localparam state_t ST_LOW     = 2'd2;

  // Written as val + tol >= centre so that an unsigned centre - tol can never underflow.
  function automatic logic in_window(input int unsigned val,
                                     input int unsigned centre,
                                     input int unsigned tol);
    return ((val + tol) >= centre) && (val <= (centre + tol));
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input, followed by registered
// single-cycle rising/falling edge pulses.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // The history flop resets low, so an input that is already high at reset
  // release produces exactly one rise pulse.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & hist_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures high phase, low phase and period of a slow square wave in system
// clock cycles, with lock detection and stuck-input timeout.
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int EXPECT_HALF = DEF_EXPECT_HALF,
  parameter int TOL         = DEF_TOL,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] high_cycles,
  output logic [CNT_W-1:0] low_cycles,
  output logic [CNT_W:0]   period_cycles,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic rise, fall;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             timed_out;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .rise_pulse (rise),
    .fall_pulse (fall)
  );

  // Timeout has priority over any edge seen in the same cycle.
  assign timed_out = (state_q != ST_ACQUIRE) && (cnt_q == TIMEOUT_C);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    high_d    = high_q;
    low_d     = low_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;

    if (timed_out) begin
      timeout_d = 1'b1;
      locked_d  = 1'b0;
      cnt_d     = '0;
      state_d   = ST_ACQUIRE;
    end else begin
      case (state_q)
        ST_ACQUIRE: begin
          if (rise) begin
            cnt_d   = CNT_W'(1);
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            high_d  = cnt_q;
            cnt_d   = CNT_W'(1);
            state_d = ST_LOW;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (rise) begin
            low_d     = cnt_q;
            period_d  = {1'b0, high_q} + {1'b0, cnt_q};
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            locked_d  = in_window(32'(high_q), EXPECT_HALF, TOL) &&
                        in_window(32'(cnt_q), EXPECT_HALF, TOL);
            cnt_d     = CNT_W'(1);
            state_d   = ST_HIGH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_ACQUIRE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACQUIRE;
      cnt_q     <= '0;
      high_q    <= '0;
      low_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      high_q    <= high_d;
      low_q     <= low_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign rise_pulse    = rise;
  assign fall_pulse    = fall;
  assign high_cycles   = high_q;
  assign low_cycles    = low_q;
  assign period_cycles = period_q;
  assign period_valid  = valid_q;
  assign locked        = locked_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed self-checking bench for clk_period_monitor with a small timebase
// (CNT_W=8, EXPECT_HALF=10, TOL=1, TIMEOUT=64).
module tb_clk_period_monitor;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             sig_in;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic [CNT_W:0]   period_cycles;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  int check_count = 0;
  int pass_count  = 0;

  int pv_count    = 0;
  int rise_count  = 0;
  int fall_count  = 0;
  int cap_high    = 0;
  int cap_low     = 0;
  int cap_period  = 0;
  int cap_locked  = 0;
  int cap_timeout = 0;

  int rise_snap;
  int fall_snap;
  int pv_snap;

  clk_period_monitor #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .EXPECT_HALF (10),
    .TOL         (1),
    .TIMEOUT     (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sig_in        (sig_in),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .high_cycles   (high_cycles),
    .low_cycles    (low_cycles),
    .period_cycles (period_cycles),
    .period_valid  (period_valid),
    .locked        (locked),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobes are counted and the result bus captured on the falling edge.
  always @(negedge clk) begin
    if (period_valid) begin
      pv_count    = pv_count + 1;
      cap_high    = int'(high_cycles);
      cap_low     = int'(low_cycles);
      cap_period  = int'(period_cycles);
      cap_locked  = int'(locked);
      cap_timeout = int'(timeout);
    end
    if (rise_pulse) rise_count = rise_count + 1;
    if (fall_pulse) fall_count = fall_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count = check_count + 1;
    if (actual === expected) pass_count = pass_count + 1;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  // Hold sig_in at a level for n sampling edges; returns 1 time unit after the last edge.
  task automatic applyStimulus(input logic level, input int n);
    sig_in = level;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rise"},   32'(rise_pulse),    0);
    checkOutput({tag, "_fall"},   32'(fall_pulse),    0);
    checkOutput({tag, "_high"},   32'(high_cycles),   0);
    checkOutput({tag, "_low"},    32'(low_cycles),    0);
    checkOutput({tag, "_period"}, 32'(period_cycles), 0);
    checkOutput({tag, "_valid"},  32'(period_valid),  0);
    checkOutput({tag, "_locked"}, 32'(locked),        0);
    checkOutput({tag, "_tmo"},    32'(timeout),       0);
  endtask

  task automatic checkPeriod(input string tag, input int count, input int hi,
                             input int lo, input int lk);
    checkOutput({tag, "_count"},  pv_count,    count);
    checkOutput({tag, "_high"},   cap_high,    hi);
    checkOutput({tag, "_low"},    cap_low,     lo);
    checkOutput({tag, "_period"}, cap_period,  hi + lo);
    checkOutput({tag, "_locked"}, cap_locked,  lk);
    checkOutput({tag, "_tmo"},    cap_timeout, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 5);

    // Nominal 10/10 waveform; the entry rise starts a fully measured period.
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 10);
    checkPeriod("t1", 1, 10, 10, 1);

    // Tolerance edges: 9/11 still locks, 10/12 drops lock but still strobes.
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 9);
    checkPeriod("t2a", 2, 10, 10, 1);
    applyStimulus(1'b0, 11);
    applyStimulus(1'b1, 10);
    checkPeriod("t2b", 3, 9, 11, 1);
    applyStimulus(1'b0, 12);
    applyStimulus(1'b1, 10);
    checkPeriod("t2c", 4, 10, 12, 0);

    // Stuck high for 70 cycles in total forces a timeout back to acquisition.
    applyStimulus(1'b1, 60);
    checkOutput("t3_tmo_set",    32'(timeout), 1);
    checkOutput("t3_lock_clr",   32'(locked),  0);
    checkOutput("t3_no_valid",   pv_count,     4);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 10);
    checkOutput("t3_tmo_sticky", 32'(timeout), 1);
    checkOutput("t3_acq_wait",   pv_count,     4);
    applyStimulus(1'b1, 10);
    checkPeriod("t3_resume", 5, 10, 10, 1);
    checkOutput("t3_tmo_clr",    32'(timeout), 0);

    // One-cycle high glitch inside a low phase.
    applyStimulus(1'b0, 6);
    rise_snap = rise_count;
    fall_snap = fall_count;
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 4);
    checkOutput("t4_rise_cnt", rise_count - rise_snap, 1);
    checkOutput("t4_fall_cnt", fall_count - fall_snap, 1);
    checkPeriod("t4_partial", 6, 10, 6, 0);
    checkOutput("t4_high_one", 32'(high_cycles), 1);
    applyStimulus(1'b1, 10);
    checkPeriod("t4_short", 7, 1, 4, 0);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 10);
    checkPeriod("t4_recover", 8, 10, 10, 1);

    // Reset in the middle of a high phase, released with sig_in still high.
    applyStimulus(1'b1, 4);
    rise_snap = rise_count;
    pv_snap   = pv_count;
    rst_n = 1'b0;
    #2;
    checkAllZero("t5_async");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 10);
    checkOutput("t5_one_rise",  rise_count - rise_snap, 1);
    checkOutput("t5_no_valid",  pv_count - pv_snap,     0);
    checkOutput("t5_high_held", 32'(high_cycles),       10);
    applyStimulus(1'b1, 10);
    checkOutput("t5_valid", pv_count - pv_snap, 1);
    checkOutput("t5_high",  cap_high,   10);
    checkOutput("t5_low",   cap_low,    10);
    checkOutput("t5_lock",  cap_locked, 1);

    // Edge latency: sampled at edge k, pulse seen only after edge k+2.
    applyStimulus(1'b0, 10);
    sig_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("t6_rise_k%0d", i), 32'(rise_pulse), (i == 2) ? 1 : 0);
    end
    applyStimulus(1'b1, 6);
    sig_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("t6_fall_k%0d", i), 32'(fall_pulse), (i == 2) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
